// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: a fixed-latency word array with big-endian byte/half lanes.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses, suppress misaligned writes and zero misaligned reads.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_2DM,
  input  logic        MemWrite_2DM,
  input  logic [31:0] data_address_2DM,
  input  logic [31:0] data_write_2DM,
  input  logic [1:0]  store_size,
  output logic [31:0] data_read_fDM,
  output logic        mem_stall,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_BYTE     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_t;

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic [DEPTH_LOG2+1:0]   addr_q;
  logic [31:0]             wdata_q;
  size_t                   size_q;
  logic                    is_write_q;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [3:0]              byte_en;
  logic [31:0]             wdata_lane;
  logic                    misaligned;
  logic                    request;
  logic                    accept;
  logic                    commit;
  logic [31:0]             mem [0:WORDS-1];

  // Upper address bits only select beyond the array and are dropped so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_address_2DM[31:DEPTH_LOG2+2];

  assign request = MemRead_2DM | MemWrite_2DM;
  assign accept  = (state == IDLE) && request;
  assign commit  = (state == BUSY) && (cnt == 4'd0);
  assign idx     = addr_q[DEPTH_LOG2+1:2];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_stall  = 1'b0;
    mem_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (request) begin
          mem_stall  = 1'b1;
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      RESP: begin
        mem_ready  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write wins when both request lines are raised together.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q     <= data_address_2DM[DEPTH_LOG2+1:0];
      wdata_q    <= data_write_2DM;
      size_q     <= size_t'(store_size);
      is_write_q <= MemWrite_2DM;
    end
  end

  // Big-endian lanes: the lowest byte address maps to bits 31:24.
  always_comb begin
    byte_en    = 4'b1111;
    wdata_lane = wdata_q;
    unique case (size_q)
      SZ_HALF: begin
        byte_en    = 4'b1100 >> {addr_q[1], 1'b0};
        wdata_lane = {2{wdata_q[15:0]}};
      end
      SZ_BYTE: begin
        byte_en    = 4'b1000 >> addr_q[1:0];
        wdata_lane = {4{wdata_q[7:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata_q;
      end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    unique case (size_q)
      SZ_WORD, SZ_WORD_ALT: misaligned = (addr_q[1:0] != 2'b00);
      SZ_HALF:              misaligned = addr_q[0];
      default:              misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) mem_error <= 1'b0;
    else        mem_error <= commit & misaligned;
  end
`else
  assign misaligned = 1'b0;
  assign mem_error  = 1'b0;
`endif

  // NOTE: the array is deliberately left out of reset; only control and the read register are cleared.
  always_ff @(posedge CLK) begin
    if (RESET && commit && is_write_q && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
      end
    end
  end

  // The read register only moves on read completions, so stores leave the last load visible.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      data_read_fDM <= 32'd0;
    end else if (commit && !is_write_q) begin
      data_read_fDM <= misaligned ? 32'd0 : mem[idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_LOG2=8, LATENCY=2).
// Expectations for the alignment cases follow DMEM_ALIGN_CHECK_EN when the bench is built with it.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic [31:0] rdata;
  logic        stall;
  logic        ready;
  logic        error;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
    .CLK              (clk),
    .RESET            (rst),
    .MemRead_2DM      (mem_read),
    .MemWrite_2DM     (mem_write),
    .data_address_2DM (addr),
    .data_write_2DM   (wdata),
    .store_size       (size),
    .data_read_fDM    (rdata),
    .mem_stall        (stall),
    .mem_ready        (ready),
    .mem_error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Drives one request for a single cycle and reports the cycle (after accept) in which mem_ready was seen.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, output int lat, output logic stall_acc,
                        output logic err, output logic [31:0] data);
    lat  = 0;
    err  = 1'bx;
    data = 32'hxxxx_xxxx;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d; size = sz;
    #1 stall_acc = stall;
    @(posedge clk);
    #1 mem_read = 1'b0; mem_write = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready) begin
        lat  = k;
        err  = error;
        data = rdata;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; size = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_word_round_trip();
    int lat; logic st; logic er; logic [31:0] d;
    access(1'b0, 1'b1, 32'h40, 32'h1234_5678, 2'b00, lat, st, er, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_wr_latency: got %0d expected 3", lat); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL word_wr_accept_stall: got %b expected 1", st); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_wr_error: got %b expected 0", er); end
    access(1'b1, 1'b0, 32'h40, 32'h0, 2'b00, lat, st, er, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_rd_latency: got %0d expected 3", lat); end
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL word_rd_data: got %h expected 12345678", d); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic st; logic er; logic [31:0] d;
    access(1'b0, 1'b1, 32'h80, 32'h0, 2'b00, lat, st, er, d);
    access(1'b0, 1'b1, 32'h81, 32'hFFFF_FFAA, 2'b10, lat, st, er, d);
    access(1'b0, 1'b1, 32'h83, 32'h0000_00BB, 2'b10, lat, st, er, d);
    access(1'b1, 1'b0, 32'h80, 32'h0, 2'b00, lat, st, er, d);
    checks++; if (d !== 32'h00AA_00BB) begin errors++; $display("FAIL byte_lanes: got %h expected 00aa00bb", d); end
  endtask

  task automatic test_half_lanes();
    int lat; logic st; logic er; logic [31:0] d;
    access(1'b0, 1'b1, 32'h84, 32'h0, 2'b00, lat, st, er, d);
    access(1'b0, 1'b1, 32'h84, 32'hFFFF_1234, 2'b01, lat, st, er, d);
    access(1'b0, 1'b1, 32'h86, 32'h0000_BEEF, 2'b01, lat, st, er, d);
    access(1'b0, 1'b1, 32'h87, 32'h0000_0077, 2'b10, lat, st, er, d);
    access(1'b1, 1'b0, 32'h84, 32'h0, 2'b00, lat, st, er, d);
    checks++; if (d !== 32'h1234_BE77) begin errors++; $display("FAIL half_lanes: got %h expected 1234be77", d); end
    access(1'b0, 1'b1, 32'h88, 32'hDEAD_BEEF, 2'b11, lat, st, er, d);
    access(1'b1, 1'b0, 32'h88, 32'h0, 2'b00, lat, st, er, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL size11_word: got %h expected deadbeef", d); end
  endtask

  task automatic test_simultaneous();
    int lat; logic st; logic er; logic [31:0] d;
    access(1'b1, 1'b0, 32'h40, 32'h0, 2'b00, lat, st, er, d);
    access(1'b1, 1'b1, 32'h10, 32'h0000_0005, 2'b00, lat, st, er, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL both_latency: got %0d expected 3", lat); end
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL both_rdata_held: got %h expected 12345678", d); end
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b00, lat, st, er, d);
    checks++; if (d !== 32'h0000_0005) begin errors++; $display("FAIL both_write_done: got %h expected 00000005", d); end
  endtask

  task automatic test_wrap();
    int lat; logic st; logic er; logic [31:0] d;
    access(1'b0, 1'b1, 32'h400, 32'h0000_CAFE, 2'b00, lat, st, er, d);
    access(1'b1, 1'b0, 32'h0, 32'h0, 2'b00, lat, st, er, d);
    checks++; if (d !== 32'h0000_CAFE) begin errors++; $display("FAIL wrap: got %h expected 0000cafe", d); end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic st; logic er; logic [31:0] d; logic seen_ready;
    access(1'b0, 1'b1, 32'h20, 32'h1122_3344, 2'b00, lat, st, er, d);
    seen_ready = 1'b0;
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF; size = 2'b00;
    @(posedge clk);
    #1 mem_write = 1'b0;
    @(negedge clk); seen_ready |= ready;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); seen_ready |= ready;
    @(posedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_state_idle: stall got %b expected 0", stall); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL abort_rdata: got %h expected 00000000", rdata); end
    repeat (2) begin @(negedge clk); seen_ready |= ready; end
    @(posedge clk);
    #1 rst = 1'b1;
    checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got %b expected 0", seen_ready); end
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b00, lat, st, er, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_latency: got %0d expected 3", lat); end
    checks++; if (d !== 32'h1122_3344) begin errors++; $display("FAIL abort_no_write: got %h expected 11223344", d); end
  endtask

  task automatic test_align();
    int lat; logic st; logic er; logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] exp_after_half;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_err = 1'b1; exp_rd = 32'h0; exp_after_half = 32'h1122_3344;
`else
    exp_err = 1'b0; exp_rd = 32'h1122_3344; exp_after_half = 32'hABCD_3344;
`endif
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b00, lat, st, er, d);
    checks++; if (lat !== 3) begin errors++; $display("FAIL align_latency: got %0d expected 3", lat); end
    checks++; if (er !== exp_err) begin errors++; $display("FAIL align_rd_error: got %b expected %b", er, exp_err); end
    checks++; if (d !== exp_rd) begin errors++; $display("FAIL align_rd_data: got %h expected %h", d, exp_rd); end
    access(1'b0, 1'b1, 32'h21, 32'h0000_ABCD, 2'b01, lat, st, er, d);
    checks++; if (er !== exp_err) begin errors++; $display("FAIL align_wr_error: got %b expected %b", er, exp_err); end
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b00, lat, st, er, d);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL aligned_rd_error: got %b expected 0", er); end
    checks++; if (d !== exp_after_half) begin errors++; $display("FAIL align_half_write: got %h expected %h", d, exp_after_half); end
  endtask

  // Request held high: RESP must ignore it, then IDLE re-accepts on the following cycle.
  task automatic test_back_to_back();
    logic [8:0] ready_bits;
    logic [8:0] stall_bits;
    ready_bits = '0;
    stall_bits = '0;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h40; size = 2'b00;
    #1 stall_bits[0] = stall;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ready_bits[c] = ready;
      stall_bits[c] = stall;
      if (ready && rdata !== 32'h1234_5678) begin
        checks++; errors++;
        $display("FAIL b2b_data: got %h expected 12345678", rdata);
      end
      if (c == 8) mem_read = 1'b0;
    end
    checks++; if (ready_bits !== 9'h088) begin errors++; $display("FAIL b2b_ready_pattern: got %h expected 088", ready_bits); end
    checks++; if (stall_bits !== 9'h177) begin errors++; $display("FAIL b2b_stall_pattern: got %h expected 177", stall_bits); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_word_round_trip();
    test_byte_lanes();
    test_half_lanes();
    test_simultaneous();
    test_wrap();
    test_reset_mid_access();
    test_align();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, log2 of the number of 32-bit words in the array.
REQ-002 SHALL have parameter LATENCY, default 2, BUSY cycles per access; legal range 1..15.
REQ-003 SHALL have port CLK, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous active-low reset: the block resets at a rising CLK edge when RESET==0.
REQ-005 SHALL have port MemRead_2DM, input, 1, read request from the MEM stage.
REQ-006 SHALL have port MemWrite_2DM, input, 1, write request from the MEM stage.
REQ-007 SHALL have port data_address_2DM, input, 32, byte address.
REQ-008 SHALL have port data_write_2DM, input, 32, store data; the stored byte or half sits in the low bits.
REQ-009 SHALL have port store_size, input, 2, store width: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-010 SHALL have port data_read_fDM, output, 32, registered read word returned to the MEM stage.
REQ-011 SHALL have port mem_stall, output, 1, pipeline hold request.
REQ-012 SHALL have port mem_ready, output, 1, one-cycle pulse marking access completion.
REQ-013 SHALL have port mem_error, output, 1, misaligned-access flag, valid while mem_ready==1.

Function
REQ-014 SHALL implement states IDLE, BUSY and RESP, held in a state register plus a 4-bit countdown counter.
REQ-015 In IDLE, when MemRead_2DM or MemWrite_2DM is 1, SHALL capture address, write data, size and operation, load counter with LATENCY-1, and go to BUSY.
REQ-016 When both request inputs are 1, SHALL treat the request as a write.
REQ-017 In BUSY, SHALL decrement the counter each cycle and go to RESP on the cycle in which it is 0.
REQ-018 mem_ready SHALL rise exactly LATENCY+1 cycles after the accept cycle.
REQ-019 In RESP, SHALL assert mem_ready=1 and mem_stall=0, ignore request inputs, and return to IDLE on the next cycle.
REQ-020 SHALL drive mem_stall as (IDLE and (MemRead_2DM or MemWrite_2DM)) or BUSY, combinationally, so it is already high in the accept cycle.
REQ-021 SHALL derive the word index from address bits [DEPTH_LOG2+1:2] and ignore upper bits, so out-of-range addresses wrap modulo the array size.
REQ-022 SHALL commit writes on the BUSY->RESP edge.
REQ-023 Writes SHALL use big-endian lanes: word writes all 32 bits.
REQ-024 A half write SHALL go to bits 31:16 when addr[1]==0 and to bits 15:0 when addr[1]==1.
REQ-025 A byte write SHALL go to lane 31:24, 23:16, 15:8 or 7:0 for addr[1:0] = 0, 1, 2, 3 respectively.
REQ-026 Reads SHALL load the full unshifted word into data_read_fDM on the BUSY->RESP edge.
REQ-027 data_read_fDM SHALL hold its value until the next read response; write accesses SHALL NOT change it.
REQ-028 Array contents SHALL be uninitialised in hardware.

Reset
REQ-029 On reset, SHALL set state to IDLE, counter to 0, data_read_fDM to 0, and mem_ready and mem_error to 0; mem_stall SHALL then follow REQ-020 from IDLE.
REQ-030 Reset during BUSY SHALL abort the access with no array write committed.
REQ-031 Reset SHALL NOT clear array contents.
REQ-032 A request present in the first cycle after reset release SHALL be accepted normally.

Configuration
REQ-033 With DMEM_ALIGN_CHECK_EN defined, a word access with addr[1:0]!=0 or a half access with addr[0]==1 SHALL assert mem_error in RESP.
REQ-034 With DMEM_ALIGN_CHECK_EN defined, a misaligned write SHALL be suppressed, and a misaligned read SHALL return 0 in data_read_fDM.
REQ-035 Without DMEM_ALIGN_CHECK_EN, mem_error SHALL be tied to 0, low address bits SHALL be used only for lane selection, and word accesses SHALL ignore addr[1:0].

Verification
REQ-036 Bench SHALL check word round trip: write 0x12345678 to 0x40, then read 0x40 -> data_read_fDM=0x12345678, mem_ready high 3 cycles after each accept.
REQ-037 Bench SHALL check byte lanes: word 0 at 0x80, then bytes 0xAA to 0x81 and 0xBB to 0x83, then read 0x80 -> 0x00AA00BB.
REQ-038 Bench SHALL check simultaneous request: MemRead_2DM=MemWrite_2DM=1 with data 0x5 at 0x10 -> write performed, data_read_fDM unchanged, later read of 0x10 returns 0x5.
REQ-039 Bench SHALL check wrap: with DEPTH_LOG2=8, write 0xCAFE to 0x400, then read 0x0 -> 0x0000CAFE.
REQ-040 Bench SHALL check reset mid-access: RESET=0 in second BUSY cycle of a write of 0xFFFFFFFF to 0x20 -> state IDLE, mem_ready never pulses, read 0x20 returns its prior value.
REQ-041 Bench SHALL check, with DMEM_ALIGN_CHECK_EN, a word read at 0x22 -> mem_error=1 with mem_ready, data_read_fDM=0; without the macro -> mem_error=0, word at 0x20 returned.
